// File: rtl/wbs_uart_rx_pkg.sv
// Shared UART frame constants and receiver state encoding; reusable by the transmitter.
package wbs_uart_rx_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } uart_rx_state_e;

endpackage

// File: rtl/wbs_uart_rx_sync_filter.sv
// Two-flop line synchronizer plus the bit-decision sampler.
// With UART_RX_MAJORITY_EN defined, sample_o is the 2-of-3 vote over the last three synchronized values.
module uart_sync_filter (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_async,
    output logic line_o,
    output logic sample_o
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], rx_async};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign line_o = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
    // hist_q[0] is the previous synchronized value, hist_q[1] the one before.
    logic [1:0] hist_q;
    logic [1:0] hist_d;

    always_comb begin
        hist_d = {hist_q[0], sync_q[1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '1;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign sample_o = (sync_q[1] & hist_q[0]) | (sync_q[1] & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign sample_o = sync_q[1];
`endif

endmodule

// File: rtl/wbs_uart_rx.sv
// UART receiver (8N1, static baud) with a one-entry holding register exposed as a read-only Wishbone slave.
// Optional macro UART_RX_MAJORITY_EN selects 3-tap majority sampling of each bit.
module wbs_uart_rx
    import wbs_uart_rx_pkg::*;
#(
    parameter int TICKS_PER_BAUD = 0,
    parameter bit DATA_INV       = 1'b1
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_ni,
    input  logic       wb_stb_i,
    output logic       wb_ack_o,
    output logic [7:0] wb_dat_o,
    input  logic       uart_rx,
    output logic       rx_valid_o,
    output logic       rx_overrun_o,
    output logic       rx_frame_err_o
);

    if (TICKS_PER_BAUD < 4) begin : g_bad_ticks
        $error("wbs_uart_rx: TICKS_PER_BAUD must be >= 4");
    end
`ifdef UART_RX_MAJORITY_EN
    if (TICKS_PER_BAUD < 6) begin : g_bad_ticks_maj
        $error("wbs_uart_rx: majority sampling needs TICKS_PER_BAUD >= 6");
    end
`endif
    if (STOP_BITS != 1) begin : g_bad_stop
        $error("wbs_uart_rx: only one stop bit is supported");
    end

    localparam int CW = (TICKS_PER_BAUD < 4) ? 2 : $clog2(TICKS_PER_BAUD);
    localparam logic [CW-1:0] LAST_TICK = CW'(TICKS_PER_BAUD - 1);
    // The majority vote is only complete one tick after mid-bit; later bits keep that offset.
`ifdef UART_RX_MAJORITY_EN
    localparam logic [CW-1:0] START_TICK = CW'(TICKS_PER_BAUD / 2);
`else
    localparam logic [CW-1:0] START_TICK = CW'(TICKS_PER_BAUD / 2 - 1);
`endif

    logic line_s;
    logic sample_s;

    uart_sync_filter u_sync_filter (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_ni),
        .rx_async (uart_rx),
        .line_o   (line_s),
        .sample_o (sample_s)
    );

    uart_rx_state_e  state_q, state_d;
    logic [CW-1:0]   baud_cnt_q, baud_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      hold_q, hold_d;
    logic            valid_q, valid_d;
    logic            overrun_q, overrun_d;
    logic            ferr_q, ferr_d;
    logic            ack_q, ack_d;
    logic [7:0]      dat_q, dat_d;
    logic            store;
    logic            frame_bad;

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q + CW'(1);
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        store      = 1'b0;
        frame_bad  = 1'b0;

        case (state_q)
            IDLE: begin
                baud_cnt_d = '0;
                if (!line_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (baud_cnt_q == START_TICK) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    state_d    = sample_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (baud_cnt_q == LAST_TICK) begin
                    baud_cnt_d = '0;
                    shift_d    = {sample_s, shift_q[7:1]};
                    bit_idx_d  = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (baud_cnt_q == LAST_TICK) begin
                    baud_cnt_d = '0;
                    if (sample_s) begin
                        store   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        state_d   = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                baud_cnt_d = '0;
                if (line_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                baud_cnt_d = '0;
                state_d    = IDLE;
            end
        endcase
    end

    // A read that acks in the same cycle as a store returns the old byte; the store's flags win.
    always_comb begin
        ack_d     = wb_stb_i & ~ack_q;
        dat_d     = ack_d ? hold_q : dat_q;
        hold_d    = store ? (shift_q ^ {8{DATA_INV}}) : hold_q;
        valid_d   = store | (valid_q & ~ack_d);
        overrun_d = ack_d ? 1'b0 : (overrun_q | (store & valid_q));
        ferr_d    = frame_bad | (ferr_q & ~ack_d);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            hold_q     <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            ferr_q     <= 1'b0;
            ack_q      <= 1'b0;
            dat_q      <= '0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
            ferr_q     <= ferr_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
        end
    end

    assign wb_ack_o       = ack_q;
    assign wb_dat_o       = dat_q;
    assign rx_valid_o     = valid_q;
    assign rx_overrun_o   = overrun_q;
    assign rx_frame_err_o = ferr_q;

endmodule

// File: tb/tb_wbs_uart_rx.sv
// Bench for wbs_uart_rx: dut0 stores line levels as sampled, dut1 uses the inverted transmitter encoding.
`timescale 1ns/1ps
module tb_wbs_uart_rx;

    localparam int TPB = 16;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       stb0 = 1'b0, stb1 = 1'b0;
    logic       rx0 = 1'b1, rx1 = 1'b1;
    logic       ack0, ack1;
    logic [7:0] dat0, dat1;
    logic       v0, ov0, fe0, v1, ov1, fe1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_start = 0;
    int t_valid0 = -1;

    // Reference model: holding byte and status flags per receiver.
    logic [7:0] m_hold [2];
    logic       m_valid [2];
    logic       m_ovr [2];
    logic       m_ferr [2];

    wbs_uart_rx #(.TICKS_PER_BAUD(TPB), .DATA_INV(1'b0)) dut0 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_stb_i(stb0), .wb_ack_o(ack0), .wb_dat_o(dat0),
        .uart_rx(rx0), .rx_valid_o(v0), .rx_overrun_o(ov0), .rx_frame_err_o(fe0)
    );

    wbs_uart_rx #(.TICKS_PER_BAUD(TPB), .DATA_INV(1'b1)) dut1 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_stb_i(stb1), .wb_ack_o(ack1), .wb_dat_o(dat1),
        .uart_rx(rx1), .rx_valid_o(v1), .rx_overrun_o(ov1), .rx_frame_err_o(fe1)
    );

    always #5 clk = ~clk;
    always @(negedge clk) cyc <= cyc + 1;
    always @(posedge v0) t_valid0 = cyc;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        for (int w = 0; w < 2; w++) begin
            m_hold[w] = 8'h00; m_valid[w] = 1'b0; m_ovr[w] = 1'b0; m_ferr[w] = 1'b0;
        end
    endfunction

    function automatic void model_frame(input int w, input logic [7:0] b, input logic stop_ok);
        if (stop_ok) begin
            if (m_valid[w]) m_ovr[w] = 1'b1;
            m_hold[w] = b;
            m_valid[w] = 1'b1;
        end else begin
            m_ferr[w] = 1'b1;
        end
    endfunction

    function automatic logic [7:0] model_read(input int w);
        m_valid[w] = 1'b0; m_ovr[w] = 1'b0; m_ferr[w] = 1'b0;
        return m_hold[w];
    endfunction

    function automatic logic [2:0] exp_status(input int w);
        return {m_valid[w], m_ovr[w], m_ferr[w]};
    endfunction

    function automatic logic [2:0] dut_status(input int w);
        return (w == 0) ? {v0, ov0, fe0} : {v1, ov1, fe1};
    endfunction

    task automatic set_line(input int w, input logic v);
        if (w == 0) rx0 = v; else rx1 = v;
    endtask

    task automatic set_stb(input int w, input logic v);
        if (w == 0) stb0 = v; else stb1 = v;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame; glitch_bit >= 0 flips that data bit for one cycle at its centre.
    task automatic send_frame(input int w, input logic [7:0] b, input logic stop_lvl,
                              input logic inv, input logic release_line, input int glitch_bit);
        logic lvl;
        @(posedge clk); #1;
        set_line(w, 1'b0);
        t_start = cyc;
        wait_cycles(TPB);
        for (int i = 0; i < 8; i++) begin
            lvl = b[i] ^ inv;
            set_line(w, lvl);
            if (i == glitch_bit) begin
                wait_cycles(TPB / 2);
                set_line(w, ~lvl);
                wait_cycles(1);
                set_line(w, lvl);
                wait_cycles(TPB / 2 - 1);
            end else begin
                wait_cycles(TPB);
            end
        end
        set_line(w, stop_lvl);
        wait_cycles(TPB);
        if (release_line) set_line(w, 1'b1);
    endtask

    task automatic do_read(input int w, output logic a, output logic [7:0] d, output logic [2:0] st);
        @(posedge clk); #1;
        set_stb(w, 1'b1);
        @(posedge clk); #1;
        a  = (w == 0) ? ack0 : ack1;
        d  = (w == 0) ? dat0 : dat1;
        st = dut_status(w);
        set_stb(w, 1'b0);
    endtask

    task automatic test_reset();
        model_reset();
        wait_cycles(3);
        checks++;
        if ({ack0, dat0, v0, ov0, fe0} !== 12'h000) begin
            errors++; $display("FAIL reset_dut0: got %h exp 000", {ack0, dat0, v0, ov0, fe0});
        end
        checks++;
        if ({ack1, dat1, v1, ov1, fe1} !== 12'h000) begin
            errors++; $display("FAIL reset_dut1: got %h exp 000", {ack1, dat1, v1, ov1, fe1});
        end
        rst_n = 1'b1;
        wait_cycles(4);
    endtask

    task automatic test_baseline();
        logic a; logic [7:0] d, e; logic [2:0] st;
        t_valid0 = -1;
        send_frame(0, 8'hA5, 1'b1, 1'b0, 1'b1, -1);
        model_frame(0, 8'hA5, 1'b1);
        checks++;
        if (t_valid0 - t_start != 155 + MAJ) begin
            errors++; $display("FAIL base_latency: got %0d exp %0d", t_valid0 - t_start, 155 + MAJ);
        end
        checks++;
        if (dut_status(0) !== exp_status(0)) begin
            errors++; $display("FAIL base_status: got %b exp %b", dut_status(0), exp_status(0));
        end
        e = model_read(0);
        do_read(0, a, d, st);
        checks++;
        if ({a, d, st} !== {1'b1, e, exp_status(0)}) begin
            errors++; $display("FAIL base_read: got %h exp %h", {a, d, st}, {1'b1, e, exp_status(0)});
        end
        wait_cycles(1);
        checks++;
        if (ack0 !== 1'b0) begin
            errors++; $display("FAIL base_ack_pulse: got %b exp 0", ack0);
        end
    endtask

    task automatic test_handshake();
        logic [7:0] e;
        @(posedge clk); #1;
        stb0 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_cycles(1);
            if (k % 2 == 0) e = model_read(0);
            checks++;
            if ({ack0, dat0} !== {(k % 2 == 0) ? 1'b1 : 1'b0, e}) begin
                errors++; $display("FAIL hs_cont_ack%0d: got %h exp %h", k, {ack0, dat0}, {(k % 2 == 0), e});
            end
        end
        stb0 = 1'b0;
        wait_cycles(2);
    endtask

    task automatic test_glitch();
        logic a; logic [7:0] d, e; logic [2:0] st;
        @(posedge clk); #1;
        rx0 = 1'b0;
        wait_cycles(4);
        rx0 = 1'b1;
        wait_cycles(2 * TPB);
        checks++;
        if (dut_status(0) !== exp_status(0)) begin
            errors++; $display("FAIL glitch_status: got %b exp %b", dut_status(0), exp_status(0));
        end
        send_frame(0, 8'h3C, 1'b1, 1'b0, 1'b1, -1);
        model_frame(0, 8'h3C, 1'b1);
        e = model_read(0);
        do_read(0, a, d, st);
        checks++;
        if ({a, d, st} !== {1'b1, e, exp_status(0)}) begin
            errors++; $display("FAIL glitch_read: got %h exp %h", {a, d, st}, {1'b1, e, exp_status(0)});
        end
    endtask

    task automatic test_overrun();
        logic a; logic [7:0] d, e; logic [2:0] st;
        send_frame(0, 8'h11, 1'b1, 1'b0, 1'b1, -1);
        model_frame(0, 8'h11, 1'b1);
        send_frame(0, 8'h22, 1'b1, 1'b0, 1'b1, -1);
        model_frame(0, 8'h22, 1'b1);
        checks++;
        if (dut_status(0) !== exp_status(0)) begin
            errors++; $display("FAIL ovr_status: got %b exp %b", dut_status(0), exp_status(0));
        end
        e = model_read(0);
        do_read(0, a, d, st);
        checks++;
        if ({a, d, st} !== {1'b1, e, exp_status(0)}) begin
            errors++; $display("FAIL ovr_read: got %h exp %h", {a, d, st}, {1'b1, e, exp_status(0)});
        end
    endtask

    task automatic test_framing_break();
        logic a; logic [7:0] d, e; logic [2:0] st;
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0, -1);
        model_frame(0, 8'h55, 1'b0);
        checks++;
        if (dut_status(0) !== exp_status(0)) begin
            errors++; $display("FAIL frame_status: got %b exp %b", dut_status(0), exp_status(0));
        end
        wait_cycles(20 * TPB);
        e = model_read(0);
        do_read(0, a, d, st);
        checks++;
        if ({a, d, st} !== {1'b1, e, exp_status(0)}) begin
            errors++; $display("FAIL break_stale_read: got %h exp %h", {a, d, st}, {1'b1, e, exp_status(0)});
        end
        wait_cycles(20 * TPB);
        checks++;
        if (dut_status(0) !== exp_status(0)) begin
            errors++; $display("FAIL break_quiet: got %b exp %b", dut_status(0), exp_status(0));
        end
        rx0 = 1'b1;
        wait_cycles(2 * TPB);
        send_frame(0, 8'h0F, 1'b1, 1'b0, 1'b1, -1);
        model_frame(0, 8'h0F, 1'b1);
        e = model_read(0);
        do_read(0, a, d, st);
        checks++;
        if ({a, d, st} !== {1'b1, e, exp_status(0)}) begin
            errors++; $display("FAIL break_recover: got %h exp %h", {a, d, st}, {1'b1, e, exp_status(0)});
        end
    endtask

    task automatic test_collision();
        logic a; logic [7:0] d, e, x, y; logic [2:0] st;
        x = 8'($urandom_range(1, 255));
        y = 8'($urandom_range(1, 255));
        send_frame(0, x, 1'b1, 1'b0, 1'b1, -1);
        model_frame(0, x, 1'b1);
        fork
            send_frame(0, y, 1'b1, 1'b0, 1'b1, -1);
            begin
                @(posedge clk); #1;
                wait_cycles(154 + MAJ);
                stb0 = 1'b1;
                wait_cycles(1);
                a = ack0; d = dat0; st = dut_status(0);
                stb0 = 1'b0;
            end
        join
        e = model_read(0);
        model_frame(0, y, 1'b1);
        checks++;
        if ({a, d, st} !== {1'b1, e, exp_status(0)}) begin
            errors++; $display("FAIL collide_read: got %h exp %h", {a, d, st}, {1'b1, e, exp_status(0)});
        end
        e = model_read(0);
        do_read(0, a, d, st);
        checks++;
        if ({a, d, st} !== {1'b1, e, exp_status(0)}) begin
            errors++; $display("FAIL collide_next: got %h exp %h", {a, d, st}, {1'b1, e, exp_status(0)});
        end
    endtask

    task automatic test_reset_mid();
        logic a; logic [7:0] d, e; logic [2:0] st;
        send_frame(0, 8'h5A, 1'b1, 1'b0, 1'b1, -1);
        model_frame(0, 8'h5A, 1'b1);
        @(posedge clk); #1;
        rx0 = 1'b0;
        wait_cycles(3 * TPB + 5);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({ack0, dat0, dut_status(0)} !== {1'b0, m_hold[0], exp_status(0)}) begin
            errors++; $display("FAIL rst_mid_outputs: got %h exp %h", {ack0, dat0, dut_status(0)},
                               {1'b0, m_hold[0], exp_status(0)});
        end
        rx0 = 1'b1;
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(2 * TPB);
        checks++;
        if (dut_status(0) !== exp_status(0)) begin
            errors++; $display("FAIL rst_no_partial: got %b exp %b", dut_status(0), exp_status(0));
        end
        send_frame(0, 8'hC3, 1'b1, 1'b0, 1'b1, -1);
        model_frame(0, 8'hC3, 1'b1);
        e = model_read(0);
        do_read(0, a, d, st);
        checks++;
        if ({a, d, st} !== {1'b1, e, exp_status(0)}) begin
            errors++; $display("FAIL rst_recover: got %h exp %h", {a, d, st}, {1'b1, e, exp_status(0)});
        end
    endtask

    task automatic test_loopback();
        logic a; logic [7:0] d, e; logic [2:0] st;
        logic [7:0] bytes [6];
        bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h81;
        for (int i = 3; i < 6; i++) bytes[i] = 8'($urandom);
        for (int i = 0; i < 6; i++) begin
            send_frame(1, bytes[i], 1'b1, 1'b1, 1'b1, -1);
            model_frame(1, bytes[i], 1'b1);
            e = model_read(1);
            do_read(1, a, d, st);
            checks++;
            if ({a, d, st} !== {1'b1, e, exp_status(1)}) begin
                errors++; $display("FAIL loop_byte%0d: got %h exp %h", i, {a, d, st}, {1'b1, e, exp_status(1)});
            end
        end
`ifdef UART_RX_MAJORITY_EN
        for (int i = 0; i < 3; i++) begin
            e = 8'($urandom);
            send_frame(1, e, 1'b1, 1'b1, 1'b1, int'($urandom_range(0, 7)));
            model_frame(1, e, 1'b1);
            e = model_read(1);
            do_read(1, a, d, st);
            checks++;
            if ({a, d, st} !== {1'b1, e, exp_status(1)}) begin
                errors++; $display("FAIL loop_glitch%0d: got %h exp %h", i, {a, d, st}, {1'b1, e, exp_status(1)});
            end
        end
`endif
    endtask

    task automatic test_random();
        logic a; logic [7:0] d, e, b; logic [2:0] st; logic ok;
        for (int i = 0; i < 10; i++) begin
            b  = 8'($urandom);
            ok = ($urandom_range(0, 3) != 0);
            send_frame(0, b, ok, 1'b0, 1'b1, -1);
            model_frame(0, b, ok);
            checks++;
            if (dut_status(0) !== exp_status(0)) begin
                errors++; $display("FAIL rand_status%0d: got %b exp %b", i, dut_status(0), exp_status(0));
            end
            if ($urandom_range(0, 1) == 1) begin
                e = model_read(0);
                do_read(0, a, d, st);
                checks++;
                if ({a, d, st} !== {1'b1, e, exp_status(0)}) begin
                    errors++; $display("FAIL rand_read%0d: got %h exp %h", i, {a, d, st}, {1'b1, e, exp_status(0)});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_baseline();
        test_handshake();
        test_glitch();
        test_overrun();
        test_framing_break();
        test_collision();
        test_reset_mid();
        test_loopback();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
